uart_rx_32: RTL and testbench
=============================

Name: uart_rx_32

Overview:
Receive-side counterpart of the team's 32-bit UART transmitter. Deserialises one frame: start bit (0), 32 data bits LSB first, one parity bit, one stop bit (1). Presents the word with a one-cycle done strobe plus parity and framing error flags. Runs on an oversampling clock and sits between the serial pin and the register/bus logic that consumes received words.

Parameters:
OVS, 16, clock cycles per bit period; even, >= 4
DATA_W, 32, data bits per frame; fixed at 32 for this protocol

Ports:
CLK_Baudin  input  1  oversampling clock, OVS x bit rate
RstRx  input  1  synchronous active-low reset, sampled on the rising edge of CLK_Baudin
RxSerialData  input  1  serial line, asynchronous to CLK_Baudin; idles high
Flag_in  input  1  parity select, same meaning as on the transmitter: 0 = even, 1 = odd; sampled at frame start
DataOut  output  32  last received word
DoneRx  output  1  one-cycle pulse when a frame completes
ParityErr  output  1  parity mismatch for the last frame
FrameErr  output  1  stop bit sampled 0 for the last frame
BusyRx  output  1  high while not in IDLE

Behaviour:
- Reset (RstRx=0 at a clock edge): state=IDLE, DataOut=0, DoneRx=0, ParityErr=0, FrameErr=0, BusyRx=0. Synchroniser flops are set to 1 (line-idle value). Reset overrides any state, including mid-frame; the partial frame is discarded and DoneRx does not pulse.
- Input path: 2-flop synchroniser, then falling-edge detect on the synchronised signal.
- Tick counter: 0..OVS-1. A "mid-bit" point is OVS/2-1 cycles after the start edge, then every OVS cycles after that.
- FSM states:
  - IDLE: on a falling edge, go to START, clear the counter, latch Flag_in.
  - START: at mid-bit, sample the line. If 1, it was a glitch; return to IDLE with no outputs changed. If 0, go to DATA with bit index 0.
  - DATA: at each mid-bit, shift the sampled bit into the shift register MSB and shift right (LSB first). After the 32nd sample, go to PARITY.
  - PARITY: at mid-bit, compare the sample with the expected parity. Expected parity is XOR of the data bits for even, and its inverse for odd. Store the mismatch; go to STOP.
  - STOP: at mid-bit, sample the line. FrameErr_next = ~sample. Go to DONE.
  - DONE: one cycle only. DataOut <= shift register; ParityErr and FrameErr are updated; DoneRx=1; return to IDLE.
- Latency: DoneRx rises exactly 1 cycle after the stop-bit mid-sample, i.e. about 34.5 bit periods plus 3 cycles (synchroniser and edge detect) after the start edge on the pin.
- DataOut and both error flags hold their values until the next DONE; they change only in the DONE cycle.
- A frame with a framing error still updates DataOut and pulses DoneRx.
- Back-to-back frames: IDLE is re-entered one cycle after the stop mid-sample. A start edge arriving during the second half of the stop bit is still accepted.
- A line held low (break) after a framing error does not retrigger: a new frame needs a high-to-low edge.
- Flag_in changes mid-frame have no effect on the frame in progress.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value is the 2-of-3 majority of the samples at mid-bit-1, mid-bit and mid-bit+1. This applies to the START check, data, parity and stop bits. State transitions still occur at mid-bit+1, so DoneRx latency grows by 1 cycle.
- Undefined: a single sample at mid-bit.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, DONE;
  - DATA_W=32;
  - parity select constants PAR_EVEN=0, PAR_ODD=1;
  - function calc_parity(data, odd).
- The transmitter must share this package.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1 and a registered falling-edge pulse output.

Test Plan:
1. OVS=16, Flag_in=0, send 0xA5A5F0F0 with parity 0 and stop 1 -> one DoneRx pulse, DataOut=0xA5A5F0F0, ParityErr=0, FrameErr=0.
2. Flag_in=1, send 0xDEADBEEF with parity 1, then immediately send 0x00000001 with parity 0 -> two DoneRx pulses, DataOut=0xDEADBEEF and then 0x00000001, no errors, no lost frame.
3. Flag_in=0, send 0xDEADBEEF with the parity bit forced to 1 -> DoneRx, DataOut=0xDEADBEEF, ParityErr=1, FrameErr=0. Then a clean frame clears ParityErr.
4. Send 0x12345678 with the stop bit forced to 0 -> DoneRx, DataOut=0x12345678, FrameErr=1.
5. Line low for 4 cycles only (a glitch shorter than OVS/2) -> returns to IDLE, no DoneRx, DataOut unchanged. With UART_RX_MAJORITY_EN, a 1-cycle dip at mid-bit of a data bit is rejected.
6. Assert RstRx=0 for 1 cycle at data bit 10 of a frame -> all outputs 0 and BusyRx=0 on the next cycle, no DoneRx for that frame. The next clean frame 0xCAFEF00D is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width, parity select and parity helper.
// Used by both the 32-bit transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } uart_state_e;

    // Parity bit the transmitter appends: even -> XOR of data, odd -> inverted.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser (resets to line-idle 1) with a registered falling-edge pulse.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fall_q  <= prev_q & ~sync2_q;
        end
    end

    assign rx_o   = sync2_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx_32.sv
// 32-bit UART receiver: start, 32 data bits LSB first, parity, stop; oversampled by OVS.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit point.
module uart_rx_32
    import uart_pkg::*;
#(
    parameter int unsigned OVS = 16
) (
    input  logic              CLK_Baudin,
    input  logic              RstRx,
    input  logic              RxSerialData,
    input  logic              Flag_in,
    output logic [DATA_W-1:0] DataOut,
    output logic              DoneRx,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              BusyRx
);

    localparam int unsigned CNT_W = $clog2(OVS);
    localparam int unsigned IDX_W = $clog2(DATA_W);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned FIRST_SMP = OVS / 2;
`else
    localparam int unsigned FIRST_SMP = OVS / 2 - 1;
`endif

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              odd_q, odd_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              busy_q;

    logic rx_sync;
    logic rx_fall;
    logic tick;
    logic bit_val;

    uart_rx_sync u_sync (
        .clk_i  (CLK_Baudin),
        .rst_ni (RstRx),
        .rx_i   (RxSerialData),
        .rx_o   (rx_sync),
        .fall_o (rx_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples; the vote completes one cycle after mid-bit.
    logic [1:0] hist_q;

    always_ff @(posedge CLK_Baudin) begin
        if (!RstRx) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rx_sync};
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) | (hist_q[0] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    // First decision point is half a bit in; every later one is a full bit apart.
    assign tick = (state_q == START) ? (cnt_q == CNT_W'(FIRST_SMP))
                                     : (cnt_q == CNT_W'(OVS - 1));

    always_ff @(posedge CLK_Baudin) begin
        if (!RstRx) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_fall) state_d = START;
            START:   if (tick) state_d = bit_val ? IDLE : DATA;
            DATA:    if (tick && idx_q == IDX_W'(DATA_W - 1)) state_d = PARITY;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = DONE;
            DONE:    state_d = rx_fall ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        odd_d     = odd_q;
        perr_d    = perr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        case (state_q)
            IDLE, DONE: begin
                cnt_d = '0;
                if (rx_fall) odd_d = Flag_in;
            end
            START: if (tick) idx_d = '0;
            DATA: if (tick) begin
                shift_d = {bit_val, shift_q[DATA_W-1:1]};
                idx_d   = idx_q + IDX_W'(1);
            end
            PARITY: if (tick) perr_d = bit_val ^ calc_parity(shift_q, odd_q);
            // Results become visible in the DONE cycle together with the strobe.
            STOP: if (tick) begin
                data_d    = shift_q;
                par_err_d = perr_q;
                frm_err_d = ~bit_val;
                done_d    = 1'b1;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK_Baudin) begin
        if (!RstRx) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            odd_q     <= 1'b0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            odd_q     <= odd_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign DataOut   = data_q;
    assign DoneRx    = done_q;
    assign ParityErr = par_err_q;
    assign FrameErr  = frm_err_q;
    assign BusyRx    = busy_q;

endmodule

// File: tb/tb_uart_rx_32.sv
// Self-checking bench for uart_rx_32: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx_32;
    import uart_pkg::*;

    localparam int OVS     = 16;
    localparam int FRAME_B = 35;
    localparam int LAT_MIN = 34 * OVS + OVS / 2 - 4;
    localparam int LAT_MAX = 34 * OVS + OVS / 2 + 12;

    typedef struct {
        logic [31:0] data;
        logic        perr;
        logic        ferr;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        flag = 1'b0;
    logic [31:0] DataOut;
    logic        DoneRx, ParityErr, FrameErr, BusyRx;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          dbl = 0;
    logic        done_prev = 1'b0;
    logic [31:0] last_data = 32'h0;
    done_t       dq[$];

    uart_rx_32 #(.OVS(OVS)) dut (
        .CLK_Baudin   (clk),
        .RstRx        (rst_n),
        .RxSerialData (rx),
        .Flag_in      (flag),
        .DataOut      (DataOut),
        .DoneRx       (DoneRx),
        .ParityErr    (ParityErr),
        .FrameErr     (FrameErr),
        .BusyRx       (BusyRx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        done_t r;
        if (DoneRx) begin
            r.data = DataOut;
            r.perr = ParityErr;
            r.ferr = FrameErr;
            r.cyc  = cyc;
            dq.push_back(r);
            if (done_prev) dbl++;
        end
        done_prev = DoneRx;
    end

    // Reference: parity bit a correct transmitter would send.
    function automatic logic model_par(input logic [31:0] d, input logic odd);
        return 1'($countones(d) % 2) ^ odd;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(OVS);
    endtask

    task automatic send_frame(input logic [31:0] d, input logic par, input logic stp,
                              input logic odd, input logic flip, input int dip_bit,
                              input int rst_bit);
        flag = odd;
        drive_bit(1'b0);
        for (int i = 0; i < 32; i++) begin
            if (flip && i == 5) flag = ~odd;
            if (i == rst_bit) begin
                rx = d[i];
                tick(OVS / 2);
                rst_n = 1'b0;
                rx    = 1'b1;
                tick(1);
                rst_n = 1'b1;
                return;
            end else if (i == dip_bit) begin
                rx = d[i];
                tick(OVS / 2);
                rx = ~d[i];
                tick(1);
                rx = d[i];
                tick(OVS / 2 - 1);
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic wait_dones(input int n, input string name);
        int b = 0;
        while (dq.size() < n && b < 2 * OVS * FRAME_B) begin
            tick(1);
            b++;
        end
        checks++;
        if (dq.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d done pulses, required %0d", name, dq.size(), n);
        end
    endtask

    task automatic pop_done(output done_t r);
        if (dq.size() > 0) begin
            r = dq.pop_front();
        end else begin
            r.data = 'x;
            r.perr = 1'bx;
            r.ferr = 1'bx;
            r.cyc  = -1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        checks += 5;
        if (DataOut !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", DataOut); end
        if (DoneRx !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", DoneRx); end
        if (ParityErr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b, required 0", ParityErr); end
        if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", FrameErr); end
        if (BusyRx !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", BusyRx); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        done_t r;
        logic [31:0] d = 32'hA5A5F0F0;
        int s;
        dq.delete();
        s = cyc;
        send_frame(d, model_par(d, PAR_EVEN), 1'b1, PAR_EVEN, 1'b0, -1, -1);
        rx = 1'b1;
        tick(4);
        wait_dones(1, "basic_wait");
        pop_done(r);
        last_data = d;
        checks += 6;
        if (r.data !== d) begin errors++; $display("FAIL basic_data: got %h, required %h", r.data, d); end
        if (r.perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b, required 0", r.perr); end
        if (r.ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b, required 0", r.ferr); end
        if (r.cyc - s < LAT_MIN || r.cyc - s > LAT_MAX) begin
            errors++; $display("FAIL basic_latency: got %0d cycles, required %0d..%0d", r.cyc - s, LAT_MIN, LAT_MAX);
        end
        if (dq.size() !== 0) begin errors++; $display("FAIL basic_extra: got %0d extra pulses, required 0", dq.size()); end
        if (BusyRx !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", BusyRx); end
    endtask

    task automatic test_back_to_back();
        done_t r;
        logic [31:0] d[2] = '{32'hDEADBEEF, 32'h00000001};
        dq.delete();
        for (int i = 0; i < 2; i++) send_frame(d[i], model_par(d[i], PAR_ODD), 1'b1, PAR_ODD, 1'b0, -1, -1);
        rx = 1'b1;
        tick(4);
        wait_dones(2, "b2b_wait");
        for (int i = 0; i < 2; i++) begin
            pop_done(r);
            checks += 3;
            if (r.data !== d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h, required %h", i, r.data, d[i]); end
            if (r.perr !== 1'b0) begin errors++; $display("FAIL b2b_perr%0d: got %b, required 0", i, r.perr); end
            if (r.ferr !== 1'b0) begin errors++; $display("FAIL b2b_ferr%0d: got %b, required 0", i, r.ferr); end
        end
        last_data = d[1];
    endtask

    task automatic test_parity_err();
        done_t r;
        dq.delete();
        send_frame(32'hDEADBEEF, 1'b1, 1'b1, PAR_EVEN, 1'b0, -1, -1);
        rx = 1'b1;
        tick(OVS);
        send_frame(32'h0F0F1234, model_par(32'h0F0F1234, PAR_EVEN), 1'b1, PAR_EVEN, 1'b0, -1, -1);
        rx = 1'b1;
        tick(4);
        wait_dones(2, "perr_wait");
        pop_done(r);
        checks += 5;
        if (r.data !== 32'hDEADBEEF) begin errors++; $display("FAIL perr_data: got %h, required deadbeef", r.data); end
        if (r.perr !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b, required 1", r.perr); end
        if (r.ferr !== 1'b0) begin errors++; $display("FAIL perr_ferr: got %b, required 0", r.ferr); end
        pop_done(r);
        if (r.perr !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b, required 0", r.perr); end
        if (ParityErr !== 1'b0) begin errors++; $display("FAIL perr_hold: got %b, required 0", ParityErr); end
        last_data = 32'h0F0F1234;
    endtask

    task automatic test_frame_err_break();
        done_t r;
        logic [31:0] d = 32'h12345678;
        dq.delete();
        send_frame(d, model_par(d, PAR_EVEN), 1'b0, PAR_EVEN, 1'b0, -1, -1);
        tick(5 * OVS);
        wait_dones(1, "ferr_wait");
        pop_done(r);
        checks += 5;
        if (r.data !== d) begin errors++; $display("FAIL ferr_data: got %h, required %h", r.data, d); end
        if (r.ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b, required 1", r.ferr); end
        if (r.perr !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b, required 0", r.perr); end
        if (dq.size() !== 0) begin errors++; $display("FAIL break_retrigger: got %0d pulses, required 0", dq.size()); end
        if (BusyRx !== 1'b0) begin errors++; $display("FAIL break_busy: got %b, required 0", BusyRx); end
        rx = 1'b1;
        tick(2 * OVS);
        last_data = d;
    endtask

    task automatic test_glitch();
        dq.delete();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(4);
        checks += 4;
        if (BusyRx !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, required 1", BusyRx); end
        tick(3 * OVS);
        if (dq.size() !== 0) begin errors++; $display("FAIL glitch_done: got %0d pulses, required 0", dq.size()); end
        if (DataOut !== last_data) begin errors++; $display("FAIL glitch_hold: got %h, required %h", DataOut, last_data); end
        if (BusyRx !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b, required 0", BusyRx); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        done_t r;
        logic [31:0] d = 32'hFFFF00FF;
        dq.delete();
        send_frame(d, model_par(d, PAR_EVEN), 1'b1, PAR_EVEN, 1'b0, 3, -1);
        rx = 1'b1;
        tick(4);
        wait_dones(1, "maj_wait");
        pop_done(r);
        checks += 2;
        if (r.data !== d) begin errors++; $display("FAIL maj_data: got %h, required %h", r.data, d); end
        if (r.perr !== 1'b0) begin errors++; $display("FAIL maj_perr: got %b, required 0", r.perr); end
        last_data = d;
    endtask
`endif

    task automatic test_reset_midframe();
        done_t r;
        logic [31:0] d = 32'hCAFEF00D;
        dq.delete();
        send_frame(32'h5A5A0FF0, 1'b0, 1'b1, PAR_EVEN, 1'b0, -1, 10);
        checks += 9;
        if (DataOut !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h, required 0", DataOut); end
        if (DoneRx !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", DoneRx); end
        if (ParityErr !== 1'b0) begin errors++; $display("FAIL rstmid_perr: got %b, required 0", ParityErr); end
        if (FrameErr !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b, required 0", FrameErr); end
        if (BusyRx !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", BusyRx); end
        last_data = 32'h0;
        tick(FRAME_B * OVS);
        if (dq.size() !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d pulses, required 0", dq.size()); end
        send_frame(d, model_par(d, PAR_EVEN), 1'b1, PAR_EVEN, 1'b0, -1, -1);
        rx = 1'b1;
        tick(4);
        wait_dones(1, "rstmid_wait");
        pop_done(r);
        if (r.data !== d) begin errors++; $display("FAIL rstmid_next_data: got %h, required %h", r.data, d); end
        if (r.perr !== 1'b0) begin errors++; $display("FAIL rstmid_next_perr: got %b, required 0", r.perr); end
        if (r.ferr !== 1'b0) begin errors++; $display("FAIL rstmid_next_ferr: got %b, required 0", r.ferr); end
        last_data = d;
    endtask

    task automatic test_random();
        done_t r;
        done_t exp_q[$];
        done_t e;
        logic  odd, stp, bad_par, flip;
        int    gap;
        dq.delete();
        for (int k = 0; k < 8; k++) begin
            e.data  = $urandom;
            odd     = 1'($urandom_range(0, 1));
            bad_par = ($urandom_range(0, 3) == 0);
            stp     = ($urandom_range(0, 3) != 0);
            flip    = 1'($urandom_range(0, 1));
            e.perr  = bad_par;
            e.ferr  = ~stp;
            e.cyc   = 0;
            exp_q.push_back(e);
            send_frame(e.data, model_par(e.data, odd) ^ bad_par, stp, odd, flip, -1, -1);
            gap = stp ? $urandom_range(0, OVS) : OVS + $urandom_range(0, OVS);
            rx  = 1'b1;
            tick(gap);
        end
        tick(4);
        wait_dones(8, "rand_wait");
        foreach (exp_q[k]) begin
            pop_done(r);
            checks += 3;
            if (r.data !== exp_q[k].data) begin errors++; $display("FAIL rand%0d_data: got %h, required %h", k, r.data, exp_q[k].data); end
            if (r.perr !== exp_q[k].perr) begin errors++; $display("FAIL rand%0d_perr: got %b, required %b", k, r.perr, exp_q[k].perr); end
            if (r.ferr !== exp_q[k].ferr) begin errors++; $display("FAIL rand%0d_ferr: got %b, required %b", k, r.ferr, exp_q[k].ferr); end
        end
        checks++;
        if (dq.size() !== 0) begin errors++; $display("FAIL rand_extra: got %0d extra pulses, required 0", dq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_err();
        test_frame_err_break();
        test_glitch();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_reset_midframe();
        test_random();
        checks++;
        if (dbl !== 0) begin errors++; $display("FAIL done_width: got %0d multi-cycle pulses, required 0", dbl); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
